// File: rtl/ref_row_streamer_if.sv
// Row stream between the reference fetcher and the interpolation datapath.
// master drives row_data/row_valid/row_idx/last_row, slave returns row_ready.
interface ref_row_streamer_if #(
    parameter int unsigned PIXEL_W = 8,
    parameter int unsigned ROW_PIX = 15,
    parameter int unsigned ROWS_W  = 5
);
    logic [ROW_PIX*PIXEL_W-1:0] row_data;
    logic                       row_valid;
    logic                       row_ready;
    logic [ROWS_W-1:0]          row_idx;
    logic                       last_row;

    modport master (
        output row_data,
        output row_valid,
        output row_idx,
        output last_row,
        input  row_ready
    );

    modport slave (
        input  row_data,
        input  row_valid,
        input  row_idx,
        input  last_row,
        output row_ready
    );
endinterface

// File: rtl/ref_row_streamer.sv
// Reference row streamer: fetches three 64-bit words per row from frame
// memory, cuts a 15-pixel window at x_off and presents it on a valid/ready
// row stream, one row per fetch, num_rows rows per block.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start, abort        block start pulse / synchronous cancel
//   base_addr, stride   word address of row 0 and row-to-row word step
//   x_off, num_rows     window pixel offset in word 0, rows per block
//   mem_rd, mem_addr    read strobe and word address
//   mem_rdata           read data, valid one cycle after mem_rd
//   row                 row stream (master side)
//   busy, done          block in progress / one-cycle completion pulse
module ref_row_streamer #(
    parameter int unsigned PIXEL_W = 8,
    parameter int unsigned ROW_PIX = 15,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned ROWS_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [2:0]        x_off,
    input  logic [ROWS_W-1:0] num_rows,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_rdata,
    output logic              busy,
    output logic              done,
    ref_row_streamer_if.master row
);
    localparam int unsigned WORD_W = 64;
    localparam int unsigned ROW_W  = ROW_PIX * PIXEL_W;
    localparam int unsigned SH_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        fcnt_q, fcnt_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [2:0]        x_off_q, x_off_d;
    logic [ROWS_W-1:0] num_rows_q, num_rows_d;
    logic [ROWS_W-1:0] row_idx_q, row_idx_d;
    logic [WORD_W-1:0] w0_q, w0_d;
    logic [WORD_W-1:0] w1_q, w1_d;
    logic [ROW_W-1:0]  row_data_q, row_data_d;
    logic              mem_rd_q, mem_rd_d;
    logic              row_valid_q, row_valid_d;
    logic              last_row_q, last_row_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [SH_W-1:0]   shift_c;
    logic [ROW_W-1:0]  window_c;

    // Third word arrives in the WAIT cycle, so it is taken straight from the bus.
    assign shift_c  = SH_W'(PIXEL_W) * SH_W'(x_off_q);
    assign window_c = ROW_W'({mem_rdata, w1_q, w0_q} >> shift_c);

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            fcnt_q      <= '0;
            row_base_q  <= '0;
            stride_q    <= '0;
            mem_addr_q  <= '0;
            x_off_q     <= '0;
            num_rows_q  <= '0;
            row_idx_q   <= '0;
            w0_q        <= '0;
            w1_q        <= '0;
            row_data_q  <= '0;
            mem_rd_q    <= 1'b0;
            row_valid_q <= 1'b0;
            last_row_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            row_base_q  <= row_base_d;
            stride_q    <= stride_d;
            mem_addr_q  <= mem_addr_d;
            x_off_q     <= x_off_d;
            num_rows_q  <= num_rows_d;
            row_idx_q   <= row_idx_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
            row_data_q  <= row_data_d;
            mem_rd_q    <= mem_rd_d;
            row_valid_q <= row_valid_d;
            last_row_q  <= last_row_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        row_base_d  = row_base_q;
        stride_d    = stride_q;
        mem_addr_d  = mem_addr_q;
        x_off_d     = x_off_q;
        num_rows_d  = num_rows_q;
        row_idx_d   = row_idx_q;
        w0_d        = w0_q;
        w1_d        = w1_q;
        row_data_d  = row_data_q;
        mem_rd_d    = 1'b0;
        row_valid_d = row_valid_q;
        last_row_d  = last_row_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    stride_d   = stride;
                    x_off_d    = x_off;
                    num_rows_d = num_rows;
                    row_base_d = base_addr;
                    row_idx_d  = '0;
                    last_row_d = 1'b0;
                    busy_d     = 1'b1;
                    if (num_rows == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_FETCH;
                        fcnt_d     = '0;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = base_addr;
                    end
                end
            end

            // fcnt counts the read being issued; data for read k lands at fcnt k+1.
            S_FETCH: begin
                if (fcnt_q == 2'd1) begin
                    w0_d = mem_rdata;
                end
                if (fcnt_q == 2'd2) begin
                    w1_d    = mem_rdata;
                    state_d = S_WAIT;
                end else begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = row_base_q + ADDR_W'(fcnt_q) + ADDR_W'(1);
                    fcnt_d     = fcnt_q + 2'd1;
                end
            end

            S_WAIT: begin
                row_data_d  = window_c;
                row_valid_d = 1'b1;
                last_row_d  = (row_idx_q == num_rows_q - ROWS_W'(1));
                state_d     = S_PRESENT;
            end

            S_PRESENT: begin
                if (row.row_ready) begin
                    row_valid_d = 1'b0;
                    last_row_d  = 1'b0;
                    if (last_row_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        row_idx_d  = row_idx_q + ROWS_W'(1);
                        row_base_d = row_base_q + stride_q;
                        mem_addr_d = row_base_q + stride_q;
                        mem_rd_d   = 1'b1;
                        fcnt_d     = '0;
                        state_d    = S_FETCH;
                    end
                end
            end

            // Reached with busy still high only for an empty block; the
            // pulse for a normal block was already raised on the last transfer.
            S_DONE: begin
                state_d = S_IDLE;
                if (busy_q) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a same-cycle row transfer.
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            mem_rd_d    = 1'b0;
            row_valid_d = 1'b0;
            last_row_d  = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
        end
    end

    assign mem_rd        = mem_rd_q;
    assign mem_addr      = mem_addr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign row.row_data  = row_data_q;
    assign row.row_valid = row_valid_q;
    assign row.row_idx   = row_idx_q;
    assign row.last_row  = last_row_q;
endmodule
